// File: rtl/lstm_bp_dout_pkg.sv
// lstm_bp_dout_pkg: shared state and phase encodings for the dout sequencer
package lstm_bp_dout_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  localparam logic PH_RD = 1'b0;
  localparam logic PH_WR = 1'b1;
endpackage

// File: rtl/lstm_bp_dout_if.sv
// lstm_bp_dout_if: control/strobe bundle between the dout sequencer and the delta datapath
interface lstm_bp_dout_if #(parameter int ADDR_WIDTH = 12, parameter int STEP_WIDTH = 4);
  logic i_start;
  logic i_stall;
  logic o_busy;
  logic o_done;
  logic o_phase;
  logic [STEP_WIDTH-1:0] o_step;
  logic o_rd_en;
  logic o_wr_en;
  logic [ADDR_WIDTH-1:0] o_addr;
  modport master (input i_start, i_stall, output o_busy, o_done, o_phase, o_step, o_rd_en, o_wr_en, o_addr);
  modport slave (output i_start, i_stall, input o_busy, o_done, o_phase, o_step, o_rd_en, o_wr_en, o_addr);
endinterface

// File: rtl/lstm_bp_slot_cnt.sv
// lstm_bp_slot_cnt: slot-cycle and cell counters with current and look-ahead slot flags
module lstm_bp_slot_cnt #(
  parameter int CNT_W    = 3,
  parameter int CELL_W   = 4,
  parameter int NUM_CELL = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [CNT_W-1:0]  i_len,
  input  logic [CNT_W-1:0]  i_len_nxt,
  output logic [CELL_W-1:0] o_cell_nxt,
  output logic              o_last,
  output logic              o_last_cell,
  output logic              o_first_nxt,
  output logic              o_last_nxt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CELL_W-1:0] cell_q, cell_d;
  assign o_last = cnt_q == i_len - 1'b1;
  assign o_last_cell = cell_q == CELL_W'(NUM_CELL - 1);
  always_comb begin
    cnt_d = i_clr ? '0 : !i_en ? cnt_q : o_last ? '0 : cnt_q + 1'b1;
    cell_d = i_clr ? '0 : (!i_en || !o_last) ? cell_q : o_last_cell ? '0 : cell_q + 1'b1;
  end
  // flags for the cycle about to be entered, so the top can register its strobes
  assign o_cell_nxt = cell_d;
  assign o_first_nxt = cnt_d == '0;
  assign o_last_nxt = cnt_d == i_len_nxt - 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      cell_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cell_q <= cell_d;
    end
  end
endmodule

// File: rtl/lstm_bp_dout_ctrl.sv
// lstm_bp_dout_ctrl: walks timesteps last-to-first, reading then writing every cell of each
module lstm_bp_dout_ctrl
  import lstm_bp_dout_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CELL   = 8,
  parameter int NUM_STEP   = 4,
  parameter int STEP_WIDTH = 4,
  parameter int DELAY_RD   = 3,
  parameter int DELAY_WR   = 2
) (
  input logic clk,
  input logic rst,
  lstm_bp_dout_if.master bus
);
  localparam int DMAX = DELAY_RD > DELAY_WR ? DELAY_RD : DELAY_WR;
  localparam int CNT_W = $clog2(DMAX + 2);
  localparam int CELL_W = $clog2(NUM_CELL + 1);
  localparam logic [CNT_W-1:0] LEN_RD = CNT_W'(DELAY_RD + 1);
  localparam logic [CNT_W-1:0] LEN_WR = CNT_W'(DELAY_WR + 1);
  state_e state_q, state_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic act, act_d, frz, clr, seg_end, last, last_cell, first_nxt, last_nxt;
  logic [CELL_W-1:0] cell_nxt;
  assign act = state_q == READ || state_q == WRITE;
  assign frz = act && bus.i_stall;
  assign seg_end = act && !bus.i_stall && last && last_cell;
  lstm_bp_slot_cnt #(.CNT_W(CNT_W), .CELL_W(CELL_W), .NUM_CELL(NUM_CELL)) u_slot (
    .clk(clk),
    .rst(rst),
    .i_en(!bus.i_stall),
    .i_clr(clr),
    .i_len(state_q == WRITE ? LEN_WR : LEN_RD),
    .i_len_nxt(state_d == WRITE ? LEN_WR : LEN_RD),
    .o_cell_nxt(cell_nxt),
    .o_last(last),
    .o_last_cell(last_cell),
    .o_first_nxt(first_nxt),
    .o_last_nxt(last_nxt)
  );
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    unique case (state_q)
      IDLE: if (bus.i_start) begin
        state_d = READ;
        step_d = STEP_WIDTH'(NUM_STEP - 1);
      end
      READ: if (seg_end) state_d = WRITE;
      WRITE: if (seg_end) begin
        state_d = step_q == '0 ? DONE : READ;
        step_d = step_q == '0 ? step_q : step_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    clr = !act || state_d != state_q;
  end
  // outputs are registered from the position being entered; a stalled edge re-presents it without strobes
  always_comb begin
    act_d = state_d == READ || state_d == WRITE;
    addr_d = act_d ? ADDR_WIDTH'(step_d) * ADDR_WIDTH'(NUM_CELL) + ADDR_WIDTH'(cell_nxt) : '0;
    rd_en_d = !frz && state_d == READ && first_nxt;
    wr_en_d = !frz && state_d == WRITE && last_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q <= '0;
      addr_q <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      addr_q <= addr_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
    end
  end
  assign bus.o_busy = state_q != IDLE;
  assign bus.o_done = state_q == DONE;
  assign bus.o_phase = state_q == WRITE ? PH_WR : PH_RD;
  assign bus.o_step = step_q;
  assign bus.o_rd_en = rd_en_q;
  assign bus.o_wr_en = wr_en_q;
  assign bus.o_addr = addr_q;
endmodule

// File: tb/tb_lstm_bp_dout_ctrl.sv
// tb_lstm_bp_dout_ctrl: scenario tasks checked against a trace-based sequence model
module tb_lstm_bp_dout_ctrl;
  localparam int NC = 8, NS = 4, DR = 3, DW = 2;
  localparam int LEN = NS * NC * (DR + DW + 2);
  localparam logic [20:0] STB = 21'h003000;
  localparam logic [20:0] DONE_V = 21'h180000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lstm_bp_dout_if #(.ADDR_WIDTH(12), .STEP_WIDTH(4)) bus ();
  lstm_bp_dout_ctrl #(.ADDR_WIDTH(12), .NUM_CELL(NC), .NUM_STEP(NS), .STEP_WIDTH(4),
                      .DELAY_RD(DR), .DELAY_WR(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [20:0] tr[LEN];
  logic [20:0] exp_v = '0;
  int cyc = 0, checks = 0, errors = 0, k = 0, m_mode = 0, m_ptr = 0;
  int n_rd, n_wr, n_done, done_at, done_first, ph_rise, n_busy;
  logic prev_ph;
  logic [11:0] rd_a[$], wr_a[$];
  int rd_c[$], wr_c[$];

  // unstalled sequence: one entry per cycle {busy,done,phase,step,rd,wr,addr}
  task automatic build_trace();
    int i = 0;
    for (int s = NS - 1; s >= 0; s--) begin
      for (int c = 0; c < NC; c++)
        for (int d = 0; d <= DR; d++) begin
          tr[i] = {1'b1, 1'b0, 1'b0, 4'(s), d == 0, 1'b0, 12'(s * NC + c)};
          i++;
        end
      for (int c = 0; c < NC; c++)
        for (int d = 0; d <= DW; d++) begin
          tr[i] = {1'b1, 1'b0, 1'b1, 4'(s), 1'b0, d == DW, 12'(s * NC + c)};
          i++;
        end
    end
  endtask

  // model: mode 0 idle, 1 running through the trace, 2 done; a stall replays the current entry without strobes
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_mode <= 0;
      exp_v <= '0;
    end else if (m_mode == 0) begin
      if (bus.i_start) begin
        m_mode <= 1;
        m_ptr <= 0;
        exp_v <= tr[0];
      end
    end else if (m_mode == 1) begin
      if (bus.i_stall) exp_v <= exp_v & ~STB;
      else if (m_ptr == LEN - 1) begin
        m_mode <= 2;
        exp_v <= DONE_V;
      end else begin
        m_ptr <= m_ptr + 1;
        exp_v <= tr[m_ptr + 1];
      end
    end else begin
      m_mode <= 0;
      exp_v <= '0;
    end
  end

  function automatic logic [20:0] obs();
    return {bus.o_busy, bus.o_done, bus.o_phase, bus.o_step, bus.o_rd_en, bus.o_wr_en, bus.o_addr};
  endfunction

  task automatic clear_stats();
    n_rd = 0; n_wr = 0; n_done = 0; done_at = -1; done_first = -1; ph_rise = 0; n_busy = 0;
    prev_ph = 1'b0;
    rd_a.delete(); wr_a.delete(); rd_c.delete(); wr_c.delete();
  endtask

  task automatic tally();
    if (bus.o_rd_en === 1'b1) begin n_rd++; rd_a.push_back(bus.o_addr); rd_c.push_back(cyc); end
    if (bus.o_wr_en === 1'b1) begin n_wr++; wr_a.push_back(bus.o_addr); wr_c.push_back(cyc); end
    if (bus.o_done === 1'b1) begin
      n_done++;
      done_at = cyc;
      if (done_first < 0) done_first = cyc;
    end
    if (bus.o_busy === 1'b1 && bus.o_done === 1'b0) n_busy++;
    if (bus.o_phase === 1'b1 && !prev_ph) ph_rise++;
    prev_ph = bus.o_phase;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== 21'h0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs()); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== 21'h0) begin errors++; $display("FAIL idle_after_reset got=%h exp=0", obs()); end
  endtask

  task automatic test_full();
    int bad = 0, sp = 0;
    clear_stats();
    k = cyc;
    bus.i_start = 1'b1;
    for (int i = 1; i <= 230; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL full_trace cyc=%0d got=%h exp=%h", cyc - k, obs(), exp_v); end
      tally();
      bus.i_start = 1'b0;
    end
    checks++;
    if (n_rd != 32 || n_wr != 32) begin errors++; $display("FAIL strobe_count rd=%0d wr=%0d exp=32/32", n_rd, n_wr); end
    checks++;
    if (rd_a.size() == 0 || rd_a[0] !== 12'd24) begin errors++; $display("FAIL first_rd_addr got=%0d exp=24", rd_a.size() ? rd_a[0] : 12'hfff); end
    if (rd_a.size() == NC * NS && wr_a.size() == NC * NS)
      for (int i = 0; i < NC * NS; i++)
        if (rd_a[i] !== 12'((NS - 1 - i / NC) * NC + i % NC) || wr_a[i] !== rd_a[i]) bad++;
    checks++;
    if (rd_a.size() != NC * NS || wr_a.size() != NC * NS || bad != 0) begin errors++; $display("FAIL addr_order bad=%0d exp=0", bad); end
    for (int i = 1; i < rd_a.size(); i++) if (rd_a[i] == rd_a[i-1] + 1 && rd_c[i] - rd_c[i-1] != DR + 1) sp++;
    for (int i = 1; i < wr_a.size(); i++) if (wr_a[i] == wr_a[i-1] + 1 && wr_c[i] - wr_c[i-1] != DW + 1) sp++;
    checks++;
    if (sp != 0) begin errors++; $display("FAIL slot_spacing bad=%0d exp=0", sp); end
    checks++;
    if ((wr_c.size() ? wr_c[0] - k : -1) != NC * (DR + 1) + DW + 1) begin errors++; $display("FAIL first_wr_cycle got=%0d exp=%0d", wr_c.size() ? wr_c[0] - k : -1, NC * (DR + 1) + DW + 1); end
    checks++;
    if (ph_rise != NS) begin errors++; $display("FAIL phase_toggles got=%0d exp=%0d", ph_rise, NS); end
    checks++;
    if (done_at - k != 225) begin errors++; $display("FAIL done_cycle got=%0d exp=225", done_at - k); end
  endtask

  task automatic test_stall_read();
    clear_stats();
    k = cyc;
    bus.i_start = 1'b1;
    for (int i = 1; i <= 236; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL stall_rd_trace cyc=%0d got=%h exp=%h", cyc - k, obs(), exp_v); end
      if (cyc >= k + 14 && cyc <= k + 18) begin
        checks++;
        if (bus.o_addr !== 12'd27 || bus.o_rd_en !== 1'b0 || bus.o_wr_en !== 1'b0) begin
          errors++; $display("FAIL stall_rd_hold cyc=%0d addr=%0d rd=%b wr=%b exp=27/0/0", cyc - k, bus.o_addr, bus.o_rd_en, bus.o_wr_en);
        end
      end
      tally();
      bus.i_start = 1'b0;
      bus.i_stall = cyc >= k + 13 && cyc <= k + 17;
    end
    bus.i_stall = 1'b0;
    checks++;
    if (n_rd != 32 || n_wr != 32) begin errors++; $display("FAIL stall_rd_count rd=%0d wr=%0d exp=32/32", n_rd, n_wr); end
    checks++;
    if (done_at - k != 230) begin errors++; $display("FAIL stall_rd_done got=%0d exp=230", done_at - k); end
  endtask

  task automatic test_stall_write();
    int n24 = 0;
    clear_stats();
    k = cyc;
    bus.i_start = 1'b1;
    for (int i = 1; i <= 232; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL stall_wr_trace cyc=%0d got=%h exp=%h", cyc - k, obs(), exp_v); end
      if (cyc == k + 35) begin
        checks++;
        if (bus.o_wr_en !== 1'b0 || bus.o_addr !== 12'd24) begin errors++; $display("FAIL wr_suppressed wr=%b addr=%0d exp=0/24", bus.o_wr_en, bus.o_addr); end
      end
      if (cyc == k + 36) begin
        checks++;
        if (bus.o_wr_en !== 1'b1 || bus.o_addr !== 12'd24) begin errors++; $display("FAIL wr_release wr=%b addr=%0d exp=1/24", bus.o_wr_en, bus.o_addr); end
      end
      tally();
      bus.i_start = 1'b0;
      bus.i_stall = cyc == k + 34;
    end
    bus.i_stall = 1'b0;
    foreach (wr_a[i]) if (wr_a[i] == 12'd24) n24++;
    checks++;
    if (n24 != 1 || n_wr != 32) begin errors++; $display("FAIL wr_once addr24=%0d wr=%0d exp=1/32", n24, n_wr); end
    checks++;
    if (done_at - k != 226) begin errors++; $display("FAIL stall_wr_done got=%0d exp=226", done_at - k); end
  endtask

  task automatic test_start_busy();
    clear_stats();
    k = cyc;
    bus.i_start = 1'b1;
    for (int i = 1; i <= 456; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL start_busy_trace cyc=%0d got=%h exp=%h", cyc - k, obs(), exp_v); end
      if (cyc == k + 227) begin
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_rd_en !== 1'b1 || bus.o_addr !== 12'd24) begin
          errors++; $display("FAIL restart_held busy=%b rd=%b addr=%0d exp=1/1/24", bus.o_busy, bus.o_rd_en, bus.o_addr);
        end
      end
      tally();
      bus.i_start = cyc == k + 100 || cyc == k + 225 || cyc == k + 226;
      bus.i_stall = cyc == k + 225 || cyc == k + 226;
    end
    bus.i_start = 1'b0;
    bus.i_stall = 1'b0;
    checks++;
    if (n_done != 2 || done_first - k != 225 || done_at - k != 451) begin
      errors++; $display("FAIL start_busy_done n=%0d first=%0d last=%0d exp=2/225/451", n_done, done_first - k, done_at - k);
    end
    checks++;
    if (n_rd != 64) begin errors++; $display("FAIL start_busy_rd got=%0d exp=64", n_rd); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    k = cyc;
    bus.i_start = 1'b1;
    for (int i = 1; i <= 340; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL reset_mid_trace cyc=%0d got=%h exp=%h", cyc - k, obs(), exp_v); end
      if (cyc == k + 100) begin
        checks++;
        if (obs() !== 21'h0) begin errors++; $display("FAIL reset_mid got=%h exp=0", obs()); end
        clear_stats();
      end
      tally();
      rst = cyc == k + 99;
      bus.i_start = cyc == k + 105;
    end
    checks++;
    if (n_rd != 32 || n_wr != 32 || n_busy != LEN) begin
      errors++; $display("FAIL reset_fresh rd=%0d wr=%0d busy=%0d exp=32/32/%0d", n_rd, n_wr, n_busy, LEN);
    end
    checks++;
    if (done_at - k != 330) begin errors++; $display("FAIL reset_fresh_done got=%0d exp=330", done_at - k); end
  endtask

  task automatic test_random_stall();
    int ns;
    bit s;
    for (int it = 0; it < 3; it++) begin
      clear_stats();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ns = 0;
      k = cyc;
      bus.i_start = 1'b1;
      for (int i = 1; i <= 700; i++) begin
        @(negedge clk);
        checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL rand_trace it=%0d cyc=%0d got=%h exp=%h", it, cyc - k, obs(), exp_v); end
        tally();
        bus.i_start = 1'b0;
        s = $urandom_range(0, 3) == 0;
        bus.i_stall = s;
        if (s && m_mode == 1) ns++;
      end
      bus.i_stall = 1'b0;
      checks++;
      if (n_rd != 32 || n_wr != 32) begin errors++; $display("FAIL rand_count it=%0d rd=%0d wr=%0d exp=32/32", it, n_rd, n_wr); end
      checks++;
      if (done_at - k != 225 + ns) begin errors++; $display("FAIL rand_done it=%0d got=%0d exp=%0d", it, done_at - k, 225 + ns); end
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_stall = 1'b0;
    build_trace();
    test_reset();
    test_full();
    test_stall_read();
    test_stall_write();
    test_start_busy();
    test_reset_mid();
    test_random_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lstm_bp_dout_ctrl.md
# lstm_bp_dout_ctrl

Sequencer for the backprop dout/dx buffer in the LSTM delta stage. One start request walks every timestep from last to first. For each timestep it reads all NUM_CELL entries, then writes all NUM_CELL entries back. It issues addresses, read strobes and write strobes with per-phase slot lengths matched to the delta datapath pipeline, and it freezes cleanly when the datapath stalls.

## Interface
- ADDR_WIDTH, 12, buffer address width
- NUM_CELL, 8, entries per timestep
- NUM_STEP, 4, timesteps per sequence; NUM_STEP*NUM_CELL must be ≤ 2^ADDR_WIDTH
- STEP_WIDTH, 4, width of the timestep index
- DELAY_RD, 3, extra hold cycles per read slot; a slot is DELAY_RD+1 cycles
- DELAY_WR, 2, extra hold cycles per write slot; a slot is DELAY_WR+1 cycles
- clk  in  1  clock; one clock domain; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  begin a sequence; sampled only in IDLE
- i_stall  in  1  datapath not ready; freezes the sequencer
- o_busy  out  1  high in every non-IDLE state
- o_done  out  1  one-cycle pulse at the end of a sequence
- o_phase  out  1  0 = read phase, 1 = write phase
- o_step  out  STEP_WIDTH  current timestep index
- o_rd_en  out  1  read strobe
- o_wr_en  out  1  write strobe
- o_addr  out  ADDR_WIDTH  buffer address, shared by reads and writes

## Operation
- States:
  - IDLE: waiting. i_start=1 moves to READ, loads step=NUM_STEP-1, cell=0, slot count=0.
  - READ: cell slots 0..NUM_CELL-1.
  - WRITE: cell slots 0..NUM_CELL-1.
  - DONE: lasts one cycle, then returns to IDLE.
- Transitions:
  - READ: after the last cycle of the cell NUM_CELL-1 slot, go to WRITE with cell=0.
  - WRITE: after the last slot, go to READ with step-1 if step≠0. If step=0, go to DONE.
- Address: o_addr = step*NUM_CELL + cell. It is held for the whole slot and is valid in READ and WRITE. It is 0 in IDLE and DONE.
- Strobes:
  - o_rd_en is high on the first cycle of each read slot only.
  - o_wr_en is high on the last cycle of each write slot only, when the datapath result is valid.
  - Exactly NUM_CELL read strobes and NUM_CELL write strobes occur per timestep.
- Stall:
  - While i_stall=1 in READ or WRITE, the state, slot count, cell and step are all frozen.
  - o_rd_en and o_wr_en are forced to 0 during the stall.
  - o_addr holds its value.
  - On release, the pending strobe fires on the resumed cycle if that cycle is a strobe cycle.
  - i_stall is ignored in IDLE and DONE.
- i_start outside IDLE is ignored; there is no queueing.
- Wrap: step is decremented only on a WRITE→READ transition, so it never underflows. cell resets to 0 at every phase change.
- Width: step*NUM_CELL is computed at ADDR_WIDTH, so there is no truncation under the legal parameter constraint.

## Timing
- Reset values: state IDLE, o_busy 0, o_done 0, o_phase 0, o_step 0, o_rd_en 0, o_wr_en 0, o_addr 0, all counters 0.
- Reset asserted mid-sequence returns to IDLE on the next edge. No further strobes are issued.
- i_start sampled high at edge k gives READ from cycle k+1, with o_rd_en=1 and o_addr=(NUM_STEP-1)*NUM_CELL.
- Unstalled cycles per timestep: NUM_CELL*(DELAY_RD+1) + NUM_CELL*(DELAY_WR+1). With the defaults this is 32+24 = 56.
- Unstalled sequence: cycles k+1..k+NUM_STEP*56, i.e. k+1..k+224 with the defaults. o_done is high at k+225. IDLE is reached at k+226.
- Every stall cycle adds exactly one cycle to this count.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package: state encoding (IDLE/READ/WRITE/DONE), phase encoding constants (PH_RD=0, PH_WR=1).
- Sub-module lstm_bp_slot_cnt:
  - Counts the slot-cycle counter and the cell index, with a per-phase slot length, enable (the inverse of stall) and clear inputs.
  - Outputs first-cycle, last-cycle and last-cell flags.
  - The FSM, step counter, address multiply-add and strobe registers stay in the top module.

## Test plan
- Reset then i_start at cycle 0 with defaults:
  - 32 o_rd_en pulses and 32 o_wr_en pulses.
  - The first read address is 24, and the addresses per timestep are 24..31, 16..23, 8..15, 0..7.
  - o_done at cycle 225.
- Slot spacing: within READ, o_rd_en pulses are 4 cycles apart. Within WRITE, o_wr_en pulses are 3 cycles apart, falling on the last slot cycle. o_phase toggles at each phase boundary.
- Stall 5 cycles in mid-READ at cell 3, step 3:
  - o_addr is held at 27.
  - No strobes during the stall.
  - o_done is delayed to cycle 230.
- Stall asserted exactly on a write-strobe cycle: o_wr_en is suppressed, then fires once on the release cycle at the same address.
- i_start is pulsed while busy, and i_start and i_stall are held high in IDLE:
  - A pulse while busy has no effect.
  - Held high in IDLE, a new sequence begins the cycle after DONE returns to IDLE.
- rst asserted at cycle 100: all outputs are at reset values the next cycle. A fresh i_start gives the full 224-cycle sequence.
